// File: rtl/dm_check_sequencer_if.sv
// Memory read-port bundle between the check sequencer and the port arbiter.
//   master (sequencer): drives mem_req/mem_addr and receives mem_gnt/mem_rdata/mem_rvalid.
//   slave  (memory/arbiter side): the reverse directions.
//   mem_req    request to the arbiter; accepted when mem_req & mem_gnt
//   mem_addr   word index requested, held while mem_req is high without a grant
//   mem_gnt    arbiter grant
//   mem_rdata  read data, qualified by mem_rvalid
//   mem_rvalid read data valid
interface dm_check_sequencer_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/dm_check_sequencer.sv
// Self-check scan controller for the data memory. A start pulse walks CHECK_WORDS
// consecutive words from BASE_IDX through the shared memory read port, one read per
// word, compares each against the expected-value table and reports the result.
// Ports:
//   clk, rst   clock (rising edge) and synchronous active-high reset
//   start      begin a scan; only sampled while idle
//   busy       scan in progress
//   done       one-cycle pulse at scan end
//   pass       scan result, valid with done, held until the next accepted start
//   timeout    scan aborted waiting for read data, held until the next start
//   err_count  saturating mismatch count
//   fail_idx   word index of the first mismatch
//   fail_data  read data at the first mismatch
//   exp_idx    expected-table index (current word index)
//   exp_data   expected word for exp_idx (combinational lookup outside)
//   mem        memory read port (master side of dm_check_sequencer_if)
module dm_check_sequencer #(
  parameter int DW           = 32,
  parameter int AW           = 10,
  parameter int BASE_IDX     = 0,
  parameter int CHECK_WORDS  = 16,
  parameter int STOP_ON_FAIL = 1,
  parameter int TIMEOUT      = 64,
  parameter int CW           = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CW-1:0]       err_count,
  output logic [AW-1:0]       fail_idx,
  output logic [DW-1:0]       fail_data,
  output logic [AW-1:0]       exp_idx,
  input  logic [DW-1:0]       exp_data,
  dm_check_sequencer_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FIN
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] FIRST_IDX  = AW'(BASE_IDX);
  // Index arithmetic is modulo 2**AW, so the last index wraps with it.
  localparam logic [AW-1:0] LAST_IDX   = AW'(BASE_IDX + CHECK_WORDS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [TW-1:0] timer;
  logic          req;
  logic          mismatch;

  assign exp_idx      = idx;
  assign mem.mem_addr = idx;
  assign mem.mem_req  = req;

  always_comb begin
    mismatch = 1'b0;
    if (mem.mem_rdata != exp_data) mismatch = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      req       <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
      fail_data <= '0;
      idx       <= '0;
      timer     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            idx       <= FIRST_IDX;
            err_count <= '0;
            fail_idx  <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            req       <= 1'b1;
          end
        end

        REQ: begin
          // No time limit on the grant; idx (and so mem_addr) holds meanwhile.
          if (mem.mem_gnt) begin
            req   <= 1'b0;
            timer <= '0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (mem.mem_rvalid) begin
            if (mismatch) begin
              if (err_count != '1) err_count <= err_count + 1'b1;
              // err_count saturates but never returns to zero, so zero means
              // no mismatch has been recorded yet in this scan.
              if (err_count == '0) begin
                fail_idx  <= idx;
                fail_data <= mem.mem_rdata;
              end
            end
            if (mismatch && (STOP_ON_FAIL != 0)) begin
              state <= FIN;
            end else if (idx == LAST_IDX) begin
              state <= FIN;
            end else begin
              idx   <= idx + 1'b1;
              req   <= 1'b1;
              state <= REQ;
            end
          end else if (timer == TIMER_LAST) begin
            // TIMEOUT WAIT cycles elapsed without read data.
            timeout <= 1'b1;
            state   <= FIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0) && !timeout;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
